// File: rtl/shazard_pkg.sv
// Shared types and constants for the load scoreboard: stall cause layout and
// default register address width.
package shazard_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;

    localparam int CAUSE_RAW_EX        = 0;
    localparam int CAUSE_RAW_PENDING   = 1;
    localparam int CAUSE_STRUCT_OR_WAW = 2;

    // Field order gives {struct_or_waw, raw_pending, raw_ex} when packed.
    typedef struct packed {
        logic struct_or_waw;
        logic raw_pending;
        logic raw_ex;
    } stall_cause_t;

endpackage

// File: rtl/shazard_scoreboard_sload_queue.sv
// In-order FIFO of outstanding load destination registers; drops pushes when
// full, ignores pops when empty, and reports both as single-cycle flags.
module sload_queue
    import shazard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEFAULT_REG_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shazard_scoreboard.sv
// Multi-load hazard scoreboard: stalls decode on load-use, in-flight RAW and
// structural/WAW conflicts. Define SHAZARD_WB_BYPASS_EN to let a completing load unblock in its own cycle.
module shazard_scoreboard
    import shazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = $clog2(NUM_REGS),
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32,
    localparam int PC_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_writes_rd,
    input  logic                  id_mem_read,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_advance,
    input  logic                  mem_resp_valid,
    output logic                  stall_pipeline,
    output logic [2:0]            stall_cause,
    output logic [PC_W-1:0]       pending_count,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  sb_error
);

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   eff_pending;
    logic [REG_ADDR_W-1:0] q_head;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_overflow;
    logic                  q_underflow;
    logic                  issue;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  bypass_pop;
    logic                  raw_ex;
    logic                  raw_pending;
    logic                  struct_or_waw;
    logic [PC_W:0]         occupancy;
    stall_cause_t          cause;

    assign issue   = ex_advance && ex_mem_read;
    assign push_ok = issue && !q_full;
    assign pop_ok  = mem_resp_valid && !q_empty;

    sload_queue #(
        .DEPTH (MAX_PENDING),
        .WIDTH (REG_ADDR_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (ex_rd_addr),
        .pop       (mem_resp_valid),
        .head      (q_head),
        .count     (pending_count),
        .full      (q_full),
        .empty     (q_empty),
        .overflow  (q_overflow),
        .underflow (q_underflow)
    );

`ifdef SHAZARD_WB_BYPASS_EN
    assign bypass_pop = pop_ok;
`else
    assign bypass_pop = 1'b0;
`endif

    // The completing head register is visible through writeback forwarding.
    always_comb begin
        eff_pending = pending;
        if (bypass_pop) begin
            eff_pending[q_head] = 1'b0;
        end
    end

    always_comb begin
        occupancy = {1'b0, pending_count} + {{PC_W{1'b0}}, ex_mem_read};

        raw_ex = ex_mem_read && (ex_rd_addr != '0) &&
                 ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                  (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

        raw_pending = (id_uses_rs1 && (id_rs1_addr != '0) && eff_pending[id_rs1_addr]) ||
                      (id_uses_rs2 && (id_rs2_addr != '0) && eff_pending[id_rs2_addr]);

        struct_or_waw = (id_mem_read && (occupancy >= (PC_W + 1)'(MAX_PENDING))) ||
                        (id_writes_rd && (id_rd_addr != '0) &&
                         (eff_pending[id_rd_addr] ||
                          (ex_mem_read && (ex_rd_addr == id_rd_addr))));

        cause = '0;
        if (raw_ex) begin
            cause.raw_ex = 1'b1;
        end else if (raw_pending) begin
            cause.raw_pending = 1'b1;
        end else if (struct_or_waw) begin
            cause.struct_or_waw = 1'b1;
        end
    end

    assign stall_cause    = cause;
    assign stall_pipeline = raw_ex || raw_pending || struct_or_waw;

    // Set after clear so a re-issued register stays marked when both happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (pop_ok && (q_head != '0)) begin
                pending[q_head] <= 1'b0;
            end
            if (push_ok && (ex_rd_addr != '0)) begin
                pending[ex_rd_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (q_overflow || q_underflow ||
                     (issue && (ex_rd_addr != '0) && pending[ex_rd_addr])) begin
            sb_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_pipeline && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shazard_scoreboard.sv
// Self-checking bench for shazard_scoreboard: directed scenarios plus random
// legal traffic compared against a queue-based reference model.
module tb_shazard_scoreboard;

    localparam int MAXP    = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd_addr;
    logic       id_writes_rd;
    logic       id_mem_read;
    logic       ex_mem_read;
    logic [4:0] ex_rd_addr;
    logic       ex_advance;
    logic       mem_resp_valid;
    logic       stall_pipeline;
    logic [2:0] stall_cause;
    logic [2:0] pending_count;
    logic [3:0] stall_cycles;
    logic       sb_error;

    int vectors;
    int miscompares;

    int q[$];
    int m_cycles;
    bit m_err;

    shazard_scoreboard #(
        .NUM_REGS    (32),
        .MAX_PENDING (MAXP),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd_addr     (id_rd_addr),
        .id_writes_rd   (id_writes_rd),
        .id_mem_read    (id_mem_read),
        .ex_mem_read    (ex_mem_read),
        .ex_rd_addr     (ex_rd_addr),
        .ex_advance     (ex_advance),
        .mem_resp_valid (mem_resp_valid),
        .stall_pipeline (stall_pipeline),
        .stall_cause    (stall_cause),
        .pending_count  (pending_count),
        .stall_cycles   (stall_cycles),
        .sb_error       (sb_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A register is outstanding exactly when a load to it is still queued.
    function automatic bit is_pend(int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit eff_pend(int r);
`ifdef SHAZARD_WB_BYPASS_EN
        if (mem_resp_valid && (q.size() > 0) && (q[0] == r)) return 1'b0;
`endif
        return is_pend(r);
    endfunction

    function automatic logic [2:0] exp_cause();
        bit rex, rp, sw;
        rex = ex_mem_read && (ex_rd_addr != 0) &&
              ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
               (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        rp  = (id_uses_rs1 && eff_pend(int'(id_rs1_addr))) ||
              (id_uses_rs2 && eff_pend(int'(id_rs2_addr)));
        sw  = (id_mem_read && (q.size() + int'(ex_mem_read) >= MAXP)) ||
              (id_writes_rd && eff_pend(int'(id_rd_addr))) ||
              (id_writes_rd && id_rd_addr != 0 && ex_mem_read && ex_rd_addr == id_rd_addr);
        if (rex) return 3'b001;
        if (rp)  return 3'b010;
        if (sw)  return 3'b100;
        return 3'b000;
    endfunction

    // Advance the model by one clock with the current inputs, then the DUT.
    task automatic clock_edge();
        logic [2:0] c;
        bit issue, full, pend_hit;
        c = exp_cause();
        if (rst) begin
            q.delete();
            m_cycles = 0;
            m_err    = 1'b0;
        end else begin
            if (c != 3'b000 && m_cycles < CNT_MAX) m_cycles++;
            issue    = ex_advance && ex_mem_read;
            full     = (q.size() >= MAXP);
            pend_hit = issue && is_pend(int'(ex_rd_addr));
            if (issue && full) m_err = 1'b1;
            if (pend_hit) m_err = 1'b1;
            if (mem_resp_valid) begin
                if (q.size() == 0) m_err = 1'b1;
                else void'(q.pop_front());
            end
            if (issue && !full) q.push_back(int'(ex_rd_addr));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_addr    = '0;
        id_rs2_addr    = '0;
        id_uses_rs1    = 1'b0;
        id_uses_rs2    = 1'b0;
        id_rd_addr     = '0;
        id_writes_rd   = 1'b0;
        id_mem_read    = 1'b0;
        ex_mem_read    = 1'b0;
        ex_rd_addr     = '0;
        ex_advance     = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
    endtask

    task automatic issue_load(input int r);
        ex_mem_read = 1'b1;
        ex_advance  = 1'b1;
        ex_rd_addr  = 5'(r);
        clock_edge();
        ex_mem_read = 1'b0;
        ex_advance  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (stall_pipeline !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_pipeline);
        end
        vectors++;
        if (stall_cause !== 3'b000) begin
            miscompares++; $display("[TB] FAIL reset_cause: got %b expected 000", stall_cause);
        end
        vectors++;
        if (pending_count !== 3'd0) begin
            miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", pending_count);
        end
        vectors++;
        if (stall_cycles !== 4'd0) begin
            miscompares++; $display("[TB] FAIL reset_cycles: got %0d expected 0", stall_cycles);
        end
        vectors++;
        if (sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", sb_error);
        end
    endtask

    task automatic test_raw();
        do_reset();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_uses_rs1 = 1'b1; id_rs1_addr = 5'd5;
        #1;
        vectors++;
        if (stall_pipeline !== 1'b1 || stall_cause !== 3'b001) begin
            miscompares++; $display("[TB] FAIL raw_ex: got %b/%b expected 1/001", stall_pipeline, stall_cause);
        end
        ex_advance = 1'b1;
        clock_edge();
        idle();
        id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5;
        #1;
        vectors++;
        if (pending_count !== 3'd1) begin
            miscompares++; $display("[TB] FAIL raw_issue_count: got %0d expected 1", pending_count);
        end
        vectors++;
        if (stall_cause !== 3'b010) begin
            miscompares++; $display("[TB] FAIL raw_pending: got %b expected 010", stall_cause);
        end
        clock_edge();
        mem_resp_valid = 1'b1;
        #1;
        vectors++;
`ifdef SHAZARD_WB_BYPASS_EN
        if (stall_cause !== 3'b000) begin
            miscompares++; $display("[TB] FAIL raw_resp_cycle: got %b expected 000", stall_cause);
        end
`else
        if (stall_cause !== 3'b010) begin
            miscompares++; $display("[TB] FAIL raw_resp_cycle: got %b expected 010", stall_cause);
        end
`endif
        clock_edge();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (stall_pipeline !== 1'b0 || pending_count !== 3'd0) begin
            miscompares++; $display("[TB] FAIL raw_after_resp: got %b/%0d expected 0/0", stall_pipeline, pending_count);
        end
        idle();
    endtask

    task automatic test_struct();
        do_reset();
        for (int r = 1; r <= 4; r++) issue_load(r);
        id_mem_read = 1'b1; id_writes_rd = 1'b1; id_rd_addr = 5'd10;
        #1;
        vectors++;
        if (pending_count !== 3'd4 || stall_cause !== 3'b100) begin
            miscompares++; $display("[TB] FAIL struct_full: got %0d/%b expected 4/100", pending_count, stall_cause);
        end
        mem_resp_valid = 1'b1;
        clock_edge();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (pending_count !== 3'd3 || stall_pipeline !== 1'b0) begin
            miscompares++; $display("[TB] FAIL struct_release: got %0d/%b expected 3/0", pending_count, stall_pipeline);
        end
        ex_mem_read = 1'b1; ex_rd_addr = 5'd11;
        #1;
        vectors++;
        if (stall_cause !== 3'b100) begin
            miscompares++; $display("[TB] FAIL struct_ex_load: got %b expected 100", stall_cause);
        end
        idle();
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) clock_edge();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (pending_count !== 3'd0 || sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL struct_drain: got %0d/%b expected 0/0", pending_count, sb_error);
        end
    endtask

    task automatic test_waw();
        do_reset();
        issue_load(7);
        id_writes_rd = 1'b1; id_rd_addr = 5'd7;
        #1;
        vectors++;
        if (stall_cause !== 3'b100) begin
            miscompares++; $display("[TB] FAIL waw_pending: got %b expected 100", stall_cause);
        end
        ex_mem_read = 1'b1; ex_advance = 1'b1; ex_rd_addr = 5'd8; mem_resp_valid = 1'b1;
        #1;
        vectors++;
`ifdef SHAZARD_WB_BYPASS_EN
        if (stall_cause !== 3'b000) begin
            miscompares++; $display("[TB] FAIL waw_resp_cycle: got %b expected 000", stall_cause);
        end
`else
        if (stall_cause !== 3'b100) begin
            miscompares++; $display("[TB] FAIL waw_resp_cycle: got %b expected 100", stall_cause);
        end
`endif
        clock_edge();
        idle();
        #1;
        vectors++;
        if (pending_count !== 3'd1) begin
            miscompares++; $display("[TB] FAIL waw_push_pop_count: got %0d expected 1", pending_count);
        end
        ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_writes_rd = 1'b1; id_rd_addr = 5'd9;
        #1;
        vectors++;
        if (stall_cause !== 3'b100) begin
            miscompares++; $display("[TB] FAIL waw_ex: got %b expected 100", stall_cause);
        end
        clock_edge();
        idle();
        mem_resp_valid = 1'b1;
        clock_edge();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_x0_underflow();
        do_reset();
        ex_mem_read = 1'b1; ex_advance = 1'b1; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b1; id_rs1_addr = 5'd0;
        #1;
        vectors++;
        if (stall_pipeline !== 1'b0) begin
            miscompares++; $display("[TB] FAIL x0_ex: got %b expected 0", stall_pipeline);
        end
        clock_edge();
        ex_mem_read = 1'b0; ex_advance = 1'b0;
        #1;
        vectors++;
        if (pending_count !== 3'd1 || stall_pipeline !== 1'b0) begin
            miscompares++; $display("[TB] FAIL x0_pending: got %0d/%b expected 1/0", pending_count, stall_pipeline);
        end
        mem_resp_valid = 1'b1;
        clock_edge();
        vectors++;
        if (pending_count !== 3'd0 || sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL x0_resp: got %0d/%b expected 0/0", pending_count, sb_error);
        end
        clock_edge();
        mem_resp_valid = 1'b0;
        clock_edge();
        vectors++;
        if (sb_error !== 1'b1) begin
            miscompares++; $display("[TB] FAIL underflow_err: got %b expected 1", sb_error);
        end
        do_reset();
        vectors++;
        if (sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL underflow_clear: got %b expected 0", sb_error);
        end
    endtask

    task automatic test_errors();
        do_reset();
        for (int r = 1; r <= 5; r++) issue_load(r);
        vectors++;
        if (pending_count !== 3'd4 || sb_error !== 1'b1) begin
            miscompares++; $display("[TB] FAIL overflow: got %0d/%b expected 4/1", pending_count, sb_error);
        end
        do_reset();
        issue_load(3);
        vectors++;
        if (sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL single_issue_err: got %b expected 0", sb_error);
        end
        issue_load(3);
        vectors++;
        if (pending_count !== 3'd2 || sb_error !== 1'b1) begin
            miscompares++; $display("[TB] FAIL double_issue: got %0d/%b expected 2/1", pending_count, sb_error);
        end
        do_reset();
    endtask

    task automatic test_stall_counter();
        do_reset();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd6; id_uses_rs1 = 1'b1; id_rs1_addr = 5'd6;
        for (int i = 0; i < 10; i++) clock_edge();
        vectors++;
        if (stall_cycles !== 4'd10) begin
            miscompares++; $display("[TB] FAIL stall_count10: got %0d expected 10", stall_cycles);
        end
        for (int i = 0; i < 10; i++) clock_edge();
        vectors++;
        if (stall_cycles !== 4'd15) begin
            miscompares++; $display("[TB] FAIL stall_saturate: got %0d expected 15", stall_cycles);
        end
        idle();
        issue_load(4);
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
        vectors++;
        if (stall_cycles !== 4'd0 || pending_count !== 3'd0 || sb_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midstream_reset: got %0d/%0d/%b expected 0/0/0",
                                    stall_cycles, pending_count, sb_error);
        end
        mem_resp_valid = 1'b1;
        clock_edge();
        mem_resp_valid = 1'b0;
        vectors++;
        if (sb_error !== 1'b1) begin
            miscompares++; $display("[TB] FAIL stale_resp_err: got %b expected 1", sb_error);
        end
    endtask

    task automatic test_random();
        logic [2:0] c;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs1_addr    = 5'($urandom_range(0, 7));
            id_rs2_addr    = 5'($urandom_range(0, 7));
            id_uses_rs1    = 1'($urandom_range(0, 1));
            id_uses_rs2    = 1'($urandom_range(0, 1));
            id_rd_addr     = 5'($urandom_range(0, 7));
            id_writes_rd   = 1'($urandom_range(0, 1));
            id_mem_read    = 1'($urandom_range(0, 1));
            ex_mem_read    = 1'($urandom_range(0, 1));
            ex_rd_addr     = 5'($urandom_range(0, 7));
            ex_advance     = 1'($urandom_range(0, 1));
            if (ex_advance && ex_mem_read && (q.size() >= MAXP || is_pend(int'(ex_rd_addr))))
                ex_advance = 1'b0;
            mem_resp_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            #1;
            c = exp_cause();
            vectors++;
            if (stall_cause !== c) begin
                miscompares++; $display("[TB] FAIL rand_cause[%0d]: got %b expected %b", n, stall_cause, c);
            end
            vectors++;
            if (stall_pipeline !== (c != 3'b000)) begin
                miscompares++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, stall_pipeline, c != 3'b000);
            end
            vectors++;
            if (pending_count !== 3'(q.size())) begin
                miscompares++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", n, pending_count, q.size());
            end
            vectors++;
            if (stall_cycles !== 4'(m_cycles)) begin
                miscompares++; $display("[TB] FAIL rand_cycles[%0d]: got %0d expected %0d", n, stall_cycles, m_cycles);
            end
            vectors++;
            if (sb_error !== m_err) begin
                miscompares++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", n, sb_error, m_err);
            end
            clock_edge();
        end
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_cycles    = 0;
        m_err       = 1'b0;
        rst         = 1'b0;
        idle();
        #1;
        test_reset();
        test_raw();
        test_struct();
        test_waw();
        test_x0_underflow();
        test_errors();
        test_stall_counter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
